// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter time-sharing one registered adder; accept-to-result latency 2 cycles.
// Result held on res_* until res_ready; req_ready stays low while any operation is in flight.
module adder_share_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_sum,
  output logic                   res_carry,
  output logic [IDW-1:0]         res_id,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_gid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_sum;
  logic             r_res_carry;
  logic [IDW-1:0]   r_res_id;
  logic             r_busy;

  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic [N_REQ-1:0] w_ready;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic [WIDTH:0]   w_add;
  logic [IDW-1:0]   w_ptr_nxt;

  // Index k positions after base, wrapping at N_REQ (which need not be a power of 2).
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req_valid[rr_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_gnt   = rr_idx(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && !rst && w_found) w_ready[w_gnt] = 1'b1;
  end

  assign w_a_sel   = req_a[int'(w_gnt)*WIDTH +: WIDTH];
  assign w_b_sel   = req_b[int'(w_gnt)*WIDTH +: WIDTH];
  assign w_add     = {1'b0, r_a} + {1'b0, r_b};
  assign w_ptr_nxt = (r_gid == IDW'(N_REQ-1)) ? '0 : r_gid + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gid       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_carry <= 1'b0;
      r_res_id    <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_gid   <= w_gnt;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_res_sum   <= w_add[WIDTH-1:0];
          r_res_carry <= w_add[WIDTH];
          r_res_id    <= r_gid;
          r_res_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          // Pointer advances only once the result is consumed, so fairness tracks completions.
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_ptr       <= w_ptr_nxt;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign res_valid = r_res_valid;
  assign res_sum   = r_res_sum;
  assign res_carry = r_res_carry;
  assign res_id    = r_res_id;
  assign busy      = r_busy;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: vector table, directed corner sequences, random scoreboard.
module tb_adder_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_sum;
  logic        res_carry;
  logic [1:0]  res_id;
  logic        busy;

  int n_chk;
  int n_err;

  adder_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] a;
    logic [31:0] b;
    int          gnt;
    logic [7:0]  sum;
    logic        carry;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge; returns just after a rising edge in IDLE.
  task automatic run_vec(input vec_t v, input string nm);
    int w;
    w = 0;
    req_valid = v.mask;
    req_a     = v.a;
    req_b     = v.b;
    res_ready = 1'b1;
    @(negedge clk);
    while (req_ready == 4'b0 && w < 8) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_ready"}, 32'(req_ready), 32'(4'b0001 << v.gnt));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk({nm, "_add_busy"},  32'(busy),      32'(1));
    chk({nm, "_add_valid"}, 32'(res_valid), 32'(0));
    @(negedge clk);
    chk({nm, "_valid"}, 32'(res_valid), 32'(1));
    chk({nm, "_sum"},   32'(res_sum),   32'(v.sum));
    chk({nm, "_carry"}, 32'(res_carry), 32'(v.carry));
    chk({nm, "_id"},    32'(res_id),    32'(v.gnt));
    @(negedge clk);
    chk({nm, "_idle_valid"}, 32'(res_valid), 32'(0));
    chk({nm, "_idle_busy"},  32'(busy),      32'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [7:0] pa[4];
  logic [7:0] pb[4];
  logic [3:0] pv;

  initial begin
    vec_t v;
    int   mptr;
    bit   mbusy;
    int   acc_cyc;
    int   e_id;
    logic [8:0] e_add;
    logic [3:0] exp_rdy;
    int   g;

    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    req_valid = 4'b1111;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;

    // Reset state, and req_ready forced low while rst is high.
    @(negedge clk);
    chk("rst_ready_comb", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_valid", 32'(res_valid), 32'(0));
    chk("rst_busy",  32'(busy),      32'(0));
    chk("rst_sum",   32'(res_sum),   32'(0));
    chk("rst_carry", 32'(res_carry), 32'(0));
    chk("rst_id",    32'(res_id),    32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    req_a = 32'h04030201;
    req_b = 32'h10101010;
    res_ready = 1'b1;

    // All requesters valid: one grant every 3 cycles in order 0,1,2,3,0.
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("rr_ready", 32'(req_ready), (c % 3 == 0) ? 32'(4'b0001 << ((c / 3) % 4)) : 32'(0));
      chk("rr_valid", 32'(res_valid), (c % 3 == 2) ? 32'(1) : 32'(0));
      if (c % 3 == 2) begin
        chk("rr_id",  32'(res_id),  32'((c / 3) % 4));
        chk("rr_sum", 32'(res_sum), 32'(8'h10 + 8'((c / 3) % 4 + 1)));
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    do_reset();

    vt[0] = '{4'b0001, 32'h00000012, 32'h00000034, 0, 8'h46, 1'b0};
    vt[1] = '{4'b1111, 32'h40302010, 32'h04030201, 1, 8'h22, 1'b0};
    vt[2] = '{4'b1001, 32'h40302010, 32'h04030201, 3, 8'h44, 1'b0};
    vt[3] = '{4'b1001, 32'h40302010, 32'h04030201, 0, 8'h11, 1'b0};
    vt[4] = '{4'b1001, 32'h40302010, 32'h04030201, 3, 8'h44, 1'b0};
    vt[5] = '{4'b1000, 32'hFF000000, 32'h01000000, 3, 8'h00, 1'b1};
    vt[6] = '{4'b0100, 32'h00FF0000, 32'h00FF0000, 2, 8'hFE, 1'b1};
    vt[7] = '{4'b0011, 32'h0000807F, 32'h00008081, 0, 8'h00, 1'b1};
    vt[8] = '{4'b0110, 32'h00AB5500, 32'h00550A00, 1, 8'h5F, 1'b0};
    for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Backpressure: ptr is 2, hold res_ready low for 5 result cycles.
    req_valid = 4'b0100;
    req_a = 32'h00900000;
    req_b = 32'h00850000;
    res_ready = 1'b0;
    @(negedge clk);
    chk("bp_accept", 32'(req_ready), 32'(4'b0100));
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("bp_add_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      res_ready = (i == 5);
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 32'(1));
      chk("bp_sum",   32'(res_sum),   32'(8'h15));
      chk("bp_carry", 32'(res_carry), 32'(1));
      chk("bp_id",    32'(res_id),    32'(2));
      chk("bp_ready", 32'(req_ready), 32'(0));
      chk("bp_busy",  32'(busy),      32'(1));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_after_valid", 32'(res_valid), 32'(0));
    chk("bp_after_busy",  32'(busy),      32'(0));
    chk("bp_after_sum",   32'(res_sum),   32'(8'h15));
    chk("bp_after_ready", 32'(req_ready), 32'(4'b1000));
    @(posedge clk); #1;
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_id", 32'(res_id), 32'(3));
    @(posedge clk); #1;

    // Reset during HOLD: move ptr to 3 first, then abort a grant to requester 3.
    v = '{4'b0100, 32'h00010000, 32'h00020000, 2, 8'h03, 1'b0};
    run_vec(v, "pre_rst");
    req_valid = 4'b1000;
    req_a = 32'h77000000;
    req_b = 32'h22000000;
    res_ready = 1'b0;
    @(negedge clk);
    chk("mid_accept", 32'(req_ready), 32'(4'b1000));
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_hold_valid", 32'(res_valid), 32'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 4'b0110;
    @(negedge clk);
    chk("mid_valid", 32'(res_valid), 32'(0));
    chk("mid_busy",  32'(busy),      32'(0));
    chk("mid_sum",   32'(res_sum),   32'(0));
    chk("mid_carry", 32'(res_carry), 32'(0));
    chk("mid_id",    32'(res_id),    32'(0));
    chk("mid_grant", 32'(req_ready), 32'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end

    // Random traffic against a transaction-level scoreboard.
    do_reset();
    pv = '0;
    for (int i = 0; i < 4; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    mptr = 0;
    mbusy = 1'b0;
    acc_cyc = 0;
    e_id = 0;
    e_add = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            pv[i] = 1'b1;
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pv[i] = 1'b0;
        end
        req_a[i*8 +: 8] = pa[i];
        req_b[i*8 +: 8] = pb[i];
      end
      req_valid = pv;
      res_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      exp_rdy = '0;
      g = 0;
      if (!mbusy) begin
        for (int k = 0; k < 4; k++) begin
          if (pv[(mptr + k) % 4]) begin
            g = (mptr + k) % 4;
            exp_rdy = 4'b0001 << g;
            break;
          end
        end
      end
      chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_busy",  32'(busy),      32'(mbusy && cyc > acc_cyc));
      chk("rnd_valid", 32'(res_valid), 32'(mbusy && cyc >= acc_cyc + 2));
      if (mbusy && cyc >= acc_cyc + 2 && res_ready) begin
        chk("rnd_sum",   32'(res_sum),   32'(e_add[7:0]));
        chk("rnd_carry", 32'(res_carry), 32'(e_add[8]));
        chk("rnd_id",    32'(res_id),    32'(e_id));
        mptr = (e_id + 1) % 4;
        mbusy = 1'b0;
      end else if (!mbusy && exp_rdy != 4'b0) begin
        mbusy = 1'b1;
        acc_cyc = cyc;
        e_id = g;
        e_add = {1'b0, pa[g]} + {1'b0, pb[g]};
        pv[g] = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter and sequencer that time-shares one registered WIDTH-bit adder among N_REQ requesters inside the tile. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, runs the add, and holds the tagged result on a single valid/ready result port until it is consumed. It sits between on-tile operand sources (pin decoders or internal sequencers) and the adder datapath that drives `uo_out`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; legal range 2..8, non-power-of-2 allowed.
- `WIDTH`, 8: operand and sum width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_ready`  out  N_REQ  per-requester accept strobe; one-hot or zero.
- `req_a`  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  operand B; same packing as `req_a`.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result consumer ready.
- `res_sum`  out  WIDTH  (A+B) mod 2^WIDTH.
- `res_carry`  out  1  bit WIDTH of A+B.
- `res_id`  out  IDW  index of the requester that owns the result; IDW = max(1, $clog2(N_REQ)).
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM has three states: IDLE, ADD, HOLD.
- Round-robin pointer `ptr` (IDW bits) resets to 0.
- IDLE:
  - Grant g is the first index i with `req_valid[i]`=1, searching ptr, ptr+1, … modulo N_REQ.
  - `req_ready[g]`=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge the block captures `req_a[g]`, `req_b[g]` and g, then moves to ADD.
  - No valid requester: all ready bits are 0 and the state stays IDLE.
- ADD: the captured operands are added at full width (WIDTH+1 bits). On the edge, `res_sum`, `res_carry` and `res_id` load from the add, `res_valid` sets to 1, and the state moves to HOLD.
- HOLD:
  - `res_*` stay stable while `res_valid`=1 and `res_ready`=0.
  - On the edge where `res_valid` and `res_ready` are both 1: `res_valid` clears, `ptr` becomes (g+1) mod N_REQ (N_REQ-1 wraps to 0), and the state returns to IDLE.
- `req_ready` is 0 in ADD and HOLD regardless of `req_valid`. Requests are sampled only in IDLE.
- Requesters must hold `req_valid` and their operands until `req_ready` is seen. A `req_valid` that drops before grant is simply not granted and no error is flagged.
- `res_sum`, `res_carry` and `res_id` keep the last result after the handshake and change only on the next ADD. They are don't-care for consumers while `res_valid`=0.
- Wrap-around: 0xFF+0x01 gives sum 0x00, carry 1. 0xFF+0xFF gives sum 0xFE, carry 1.
- Reset behaviour:
  - While `rst`=1, `req_ready` is forced to 0.
  - On the edge with `rst`=1: state goes to IDLE, `ptr`=0, `res_valid`=0, `res_sum`=0, `res_carry`=0, `res_id`=0, and `busy`=0.
  - An in-flight operation (ADD or HOLD) is discarded and no result is produced.
  - Reset overrides a simultaneous request or result handshake.

## Timing
- Accept in cycle T (IDLE, `req_ready[g]`=1).
- Cycle T+1 is ADD; `busy`=1 from T+1.
- `res_valid`=1 from cycle T+2.
- With `res_ready` held at 1, the handshake occurs in T+2 and IDLE is back in T+3, where the next accept can happen.
- Peak throughput is one result per 3 cycles. Latency is accept to `res_valid` = 2 cycles.
- Every output is driven from registers except `req_ready`, which is combinational from state, `ptr`, `req_valid` and `rst`.
- There is no combinational path from `res_ready` to any output.

## Test plan
- Single request: `req_valid`=0001, A=0x12, B=0x34 held.
  - `req_ready`=0001 in the accept cycle; `res_valid` 2 cycles later with sum 0x46, carry 0, id 0.
  - `busy` is high in the ADD and HOLD cycles.
- All four requesters valid continuously, `res_ready`=1:
  - Grant order 0,1,2,3,0 from reset, one grant every 3 cycles.
  - `res_id` follows the same sequence; `req_ready` is never multi-hot.
- Backpressure: hold `res_ready`=0 for 5 cycles after `res_valid` rises.
  - `res_sum`, `res_carry` and `res_id` are stable and all `req_ready` are 0 throughout.
  - The handshake completes on the cycle `res_ready` rises; IDLE follows.
- Carry and wrap:
  - Requester 3 sends 0xFF+0x01: expect sum 0x00, carry 1, id 3.
  - Requester 2 sends 0xFF+0xFF: expect sum 0xFE, carry 1.
- Pointer wrap: with N_REQ=4, after granting 3, assert `req_valid`=1001. Expect grant 0, then 3.
- Reset mid-operation: assert `rst` for one cycle while in HOLD with `res_valid`=1.
  - Next cycle: `res_valid`=0, `busy`=0, all `res_*` = 0.
  - A pending request from requester 2 is then granted with `ptr` back at 0; with `req_valid`=0110, grant goes to 1.
